fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 33 +++
 rtl/instr_mem.sv | 22 ++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for fetch_stage and decode_stage.
// Holds the word and opcode field widths, the NOP and HALT encodings,
// the fetch FSM state encoding and the IF/ID register layout.
package fetch_stage_pkg;

  localparam int WORD_W = 32;
  localparam int OP_W   = 6;

  localparam logic [WORD_W-1:0] NOP_WORD  = 32'h0000_0000;
  localparam logic [WORD_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } ifid_t;

  // Bubble entry: carries the given NOP word and no PC
  function automatic ifid_t ifid_bubble(input logic [WORD_W-1:0] nop);
    ifid_t b;
    b.instr    = nop;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: MEM_DEPTH 32-bit words, combinational read.
// Contents are written into the array by the environment; INIT_FILE names
// the intended image.
// Ports:
//   addr  in  word address
//   data  out word at addr (combinational)
module instr_mem
  import fetch_stage_pkg::*;
#(
  parameter int    MEM_DEPTH = 64,
  parameter string INIT_FILE = "instr.mem",
  localparam int   AW        = $clog2(MEM_DEPTH)
) (
  input  logic [AW-1:0]     addr,
  output logic [WORD_W-1:0] data
);

  logic [WORD_W-1:0] mem [MEM_DEPTH];

  assign data = mem[addr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID register and a RUN/HALT FSM.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   stall          hold PC and IF/ID (decode hazard), ignored in HALT
//   branch_taken   redirect to branch_target and flush IF/ID; beats stall
//   branch_target  redirect address, bits [1:0] ignored
//   instruccion    IF/ID instruction
//   pc_plus4       IF/ID PC+4 of the held instruction
//   valid          IF/ID holds a real fetched word
//   halted         FSM is in HALT
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                MEM_DEPTH = 64,
  parameter string             INIT_FILE = "instr.mem",
  parameter logic [WORD_W-1:0] NOP       = NOP_WORD,
  parameter logic [WORD_W-1:0] HALT      = HALT_WORD,
  localparam int               AW        = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  output logic [WORD_W-1:0] instruccion,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              valid,
  output logic              halted
);

  fetch_state_t      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  ifid_t             ifid_q, ifid_d;
  logic [WORD_W-1:0] fetch_word;
  logic [WORD_W-1:0] pc_inc;
  logic              unused_tgt_lsb;

  assign unused_tgt_lsb = ^branch_target[1:0];
  assign pc_inc         = pc_q + 32'd4;

  // Upper PC bits beyond the memory are dropped, so fetch wraps modulo depth
  instr_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_mem (
    .addr (pc_q[AW+1:2]),
    .data (fetch_word)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    if (branch_taken) begin
      pc_d    = {branch_target[WORD_W-1:2], 2'b00};
      ifid_d  = ifid_bubble(NOP);
      state_d = ST_RUN;
    end else if (state_q == ST_HALT) begin
      ifid_d = ifid_bubble(NOP);
    end else if (!stall) begin
      ifid_d.instr    = fetch_word;
      ifid_d.pc_plus4 = pc_inc;
      ifid_d.valid    = 1'b1;
      // The HALT word itself goes down the pipe; PC parks on it
      if (fetch_word == HALT) state_d = ST_HALT;
      else                    pc_d    = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      ifid_q  <= ifid_bubble(NOP);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
    end
  end

  assign instruccion = ifid_q.instr;
  assign pc_plus4    = ifid_q.pc_plus4;
  assign valid       = ifid_q.valid;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized stall/branch/reset traffic against a behavioural model.
module tb_fetch_stage;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] instruccion, pc_plus4;
  logic        valid, halted;

  fetch_stage #(
    .MEM_DEPTH (DEPTH),
    .INIT_FILE ("")
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instruccion   (instruccion),
    .pc_plus4      (pc_plus4),
    .valid         (valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [31:0] mem_img [DEPTH];
  logic [31:0] m_pc, m_ins, m_p4;
  logic        m_v, m_h;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  // One clock of architectural behaviour
  task automatic model_step(input bit r, input bit s, input bit b, input logic [31:0] t);
    logic [31:0] w;
    if (r) begin
      m_pc = 0; m_ins = 32'h0; m_p4 = 0; m_v = 0; m_h = 0;
    end else if (b) begin
      m_pc = t - (t % 4); m_ins = 32'h0; m_p4 = 0; m_v = 0; m_h = 0;
    end else if (m_h) begin
      m_ins = 32'h0; m_p4 = 0; m_v = 0;
    end else if (!s) begin
      w = mem_img[(m_pc / 4) % DEPTH];
      m_ins = w; m_p4 = m_pc + 4; m_v = 1;
      if (w == 32'hFFFF_FFFF) m_h = 1;
      else                    m_pc = m_pc + 4;
    end
  endtask

  // Apply inputs for one edge, advance model, compare all outputs
  task automatic cycle(input bit r, input bit s, input bit b, input logic [31:0] t);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_step(r, s, b, t);
    #1;
    chk("instr", instruccion, m_ins);
    chk("pc_plus4", pc_plus4, m_p4);
    chk("valid", {31'd0, valid}, {31'd0, m_v});
    chk("halted", {31'd0, halted}, {31'd0, m_h});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0);
  endtask

  initial begin
    logic [31:0] seq [4];
    seq[0] = 32'h0000_0001; seq[1] = 32'h8000_0001;
    seq[2] = 32'h8001_0001; seq[3] = 32'hA000_0001;
    for (int i = 0; i < DEPTH; i++) begin
      mem_img[i] = $urandom();
      if (mem_img[i] == 32'hFFFF_FFFF) mem_img[i] = 32'h1234_5678;
    end
    for (int i = 0; i < 4; i++) mem_img[i] = seq[i];
    mem_img[4] = 32'hFFFF_FFFF;
    for (int i = 0; i < DEPTH; i++) dut.u_mem.mem[i] = mem_img[i];
    m_pc = 0; m_ins = 0; m_p4 = 0; m_v = 0; m_h = 0;

    // reset with stall and branch asserted must still give the reset state
    cycle(1, 1, 1, 32'h20);
    chk("rst_instr", instruccion, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // sequential fetch
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 32'h0);
      chk("seq_instr", instruccion, seq[i]);
      chk("seq_p4", pc_plus4, 32'(4 * (i + 1)));
      chk("seq_valid", {31'd0, valid}, 32'd1);
    end

    // halt: HALT word latched valid, then bubbles, pc parked at 16
    cycle(0, 0, 0, 32'h0);
    chk("halt_instr", instruccion, 32'hFFFF_FFFF);
    chk("halt_valid", {31'd0, valid}, 32'd1);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, i[0], 0, 32'h0);
      chk("halt_bubble", instruccion, 32'h0);
      chk("halt_pc", dut.pc_q, 32'd16);
    end

    // halt exit via branch to 0
    cycle(0, 0, 1, 32'h0);
    chk("hexit_halted", {31'd0, halted}, 32'd0);
    cycle(0, 0, 0, 32'h0);
    chk("hexit_instr", instruccion, seq[0]);
    chk("hexit_p4", pc_plus4, 32'd4);

    // stall after 2nd fetch
    cycle(1, 0, 0, 32'h0);
    run(2);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, 32'h0);
      chk("stall_instr", instruccion, 32'h8000_0001);
      chk("stall_p4", pc_plus4, 32'd8);
    end
    cycle(0, 0, 0, 32'h0);
    chk("unstall_instr", instruccion, 32'h8001_0001);

    // branch beats stall, target low bits dropped
    cycle(0, 1, 1, 32'h0000_000B);
    chk("brst_instr", instruccion, 32'h0);
    chk("brst_valid", {31'd0, valid}, 32'd0);
    cycle(0, 0, 0, 32'h0);
    chk("brst_next", instruccion, seq[2]);
    chk("brst_p4", pc_plus4, 32'd12);

    // memory-index wrap
    cycle(0, 0, 1, 32'h0000_0100);
    cycle(0, 0, 0, 32'h0);
    chk("wrap_instr", instruccion, seq[0]);
    chk("wrap_p4", pc_plus4, 32'h104);

    // 32-bit PC wrap
    cycle(0, 0, 1, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 32'h0);
    chk("pcwrap_p4", pc_plus4, 32'h0);
    cycle(0, 0, 0, 32'h0);
    chk("pcwrap_instr", instruccion, seq[0]);

    // reset mid-stall
    run(2);
    cycle(1, 1, 0, 32'h0);
    chk("midrst_p4", pc_plus4, 32'h0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    cycle(0, 0, 0, 32'h0);
    chk("midrst_instr", instruccion, seq[0]);
    chk("midrst_p4b", pc_plus4, 32'd4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit r, s, b;
      logic [31:0] t;
      r = ($urandom_range(99) < 2);
      s = ($urandom_range(99) < 30);
      b = ($urandom_range(99) < 10);
      t = ($urandom_range(3) == 0) ? $urandom() : 32'($urandom_range(4 * DEPTH - 1));
      cycle(r, s, b, t);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
